// File: rtl/router_dest_fifo.sv
// router_dest_fifo: per-destination packet byte buffer of the 1x3 router.
// Entries are {header_marker, byte}; reads are registered (data_out valid the
// cycle after an accepted read_en). pkt_cnt tracks the bytes remaining in the
// packet currently being drained.
// Optional feature macro: ROUTER_DEST_FIFO_TIMEOUT_EN adds an idle-read
// watchdog that flushes the buffer and pulses the timeout output.
module router_dest_fifo #(
  parameter int DEPTH          = 16,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             empty
`ifdef ROUTER_DEST_FIFO_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Reject configurations the pointer scheme cannot represent.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || WIDTH < 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("router_dest_fifo: unsupported parameter set");
  end

  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [5:0]     pkt_cnt;
  logic [WIDTH:0] rd_entry;
  logic           wr_acc;
  logic           rd_acc;
  logic           tmo_hit;
  logic           flush;

  // Header entries reload the remaining-byte count (payload plus parity);
  // any other byte consumes one, never going below zero.
  function automatic logic [5:0] pkt_next(input logic [WIDTH:0] entry, input logic [5:0] cnt);
    if (entry[WIDTH])
      return entry[7:2] + 6'd1;
    else if (cnt == 6'd0)
      return 6'd0;
    else
      return cnt - 6'd1;
  endfunction

  // The extra pointer MSB distinguishes a full wrap from an empty buffer.
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign valid_out = ~empty;
  assign wr_acc    = write_enb && !full;
  assign rd_acc    = read_en && !empty;
  assign rd_entry  = mem[rd_ptr[AW-1:0]];
  assign flush     = soft_reset || tmo_hit;

`ifdef ROUTER_DEST_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt;
  logic          idle_cond;

  assign idle_cond = valid_out && !read_en;
  assign tmo_hit   = idle_cond && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Watchdog: count unread-data cycles, fire a one-cycle flush pulse at the limit.
  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      idle_cnt <= '0;
      timeout  <= 1'b0;
    end else if (tmo_hit) begin
      idle_cnt <= '0;
      timeout  <= 1'b1;
    end else begin
      timeout  <= 1'b0;
      idle_cnt <= idle_cond ? idle_cnt + TW'(1) : '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Storage write; contents are don't-care after reset or flush.
  always_ff @(posedge clock) begin
    if (wr_acc)
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
  end

  // Pointer and packet-count control; a flush discards concurrent accesses.
  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= 6'd0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        pkt_cnt <= pkt_next(rd_entry, pkt_cnt);
      end
    end
  end

  // Registered read port: holds its value unless a read is accepted.
  always_ff @(posedge clock) begin
    if (!resetn || flush)
      data_out <= '0;
    else if (rd_acc)
      data_out <= rd_entry[WIDTH-1:0];
  end

endmodule

// File: tb/tb_router_dest_fifo.sv
// Testbench for router_dest_fifo: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_router_dest_fifo;

  localparam int DEPTH = 16;
  localparam int TMO   = 30;

  logic       clock = 1'b0;
  logic       resetn, soft_reset, write_enb, lfd_state, read_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out, full, empty;
`ifdef ROUTER_DEST_FIFO_TIMEOUT_EN
  logic       timeout;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8:0] q[$];
  logic [7:0] m_dout;
  logic [5:0] m_pkt;
  int         m_idle;
  logic       m_tmo;

  always #5 clock = ~clock;

  router_dest_fifo #(.DEPTH(DEPTH), .WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .read_en   (read_en),
    .data_out  (data_out),
    .valid_out (valid_out),
    .full      (full),
    .empty     (empty)
`ifdef ROUTER_DEST_FIFO_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: model consumes the current inputs, then outputs are compared.
  task automatic cycle();
    logic [8:0] e;
    bit rd, wr, hit;
    hit = 1'b0;
`ifdef ROUTER_DEST_FIFO_TIMEOUT_EN
    hit = (q.size() > 0) && !read_en && (m_idle == TMO - 1);
`endif
    if (!resetn) begin
      q.delete(); m_dout = 8'h00; m_pkt = 6'd0; m_idle = 0; m_tmo = 1'b0;
    end else if (soft_reset || hit) begin
      q.delete(); m_dout = 8'h00; m_pkt = 6'd0; m_idle = 0; m_tmo = hit && !soft_reset;
    end else begin
      rd = read_en && (q.size() != 0);
      wr = write_enb && (q.size() < DEPTH);
      m_tmo = 1'b0;
      if (q.size() > 0 && !read_en) m_idle++; else m_idle = 0;
      if (rd) begin
        e = q.pop_front();
        m_dout = e[7:0];
        if (e[8]) m_pkt = e[7:2] + 6'd1;
        else if (m_pkt != 6'd0) m_pkt = m_pkt - 6'd1;
      end
      if (wr) q.push_back({lfd_state, data_in});
    end
    @(posedge clock);
    #1;
    check("empty",     32'(empty),       32'(q.size() == 0));
    check("full",      32'(full),        32'(q.size() == DEPTH));
    check("valid_out", 32'(valid_out),   32'(q.size() != 0));
    check("data_out",  32'(data_out),    32'(m_dout));
    check("pkt_cnt",   32'(dut.pkt_cnt), 32'(m_pkt));
`ifdef ROUTER_DEST_FIFO_TIMEOUT_EN
    check("timeout",   32'(timeout),     32'(m_tmo));
`endif
  endtask

  task automatic drive(input logic we, input logic lfd, input logic [7:0] d, input logic re);
    write_enb = we; lfd_state = lfd; data_in = d; read_en = re;
    cycle();
  endtask

  initial begin
    logic [7:0] pkt [5];
    int n;
    bit seen;
    pkt[0] = 8'h0D; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'h3D;
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0;
    data_in = 8'h00; read_en = 1'b0;

    // Reset held for two cycles
    cycle(); cycle();
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_dout",  32'(data_out), 32'h0);
    resetn = 1'b1;

    // Packet round trip
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, pkt[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("rt_byte", 32'(data_out), 32'(pkt[i]));
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("rt_empty", 32'(empty), 32'd1);
    check("rt_pkt0",  32'(dut.pkt_cnt), 32'd0);

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    drive(1'b1, 1'b0, 8'hFF, 1'b0);
    check("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("drain_byte", 32'(data_out), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous read/write at occupancy 15 across pointer wrap
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b0, 8'(8'h80 + i), 1'b1);
      check("wrap_occ",  32'(5'(dut.wr_ptr - dut.rd_ptr)), 32'd15);
      check("wrap_full", 32'(full), 32'd0);
    end

    // soft_reset with 8 stored entries and a concurrent write
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("flush_pre_occ", 32'(5'(dut.wr_ptr - dut.rd_ptr)), 32'd16);
    resetn = 1'b0; drive(1'b0, 1'b0, 8'h00, 1'b0); resetn = 1'b1;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
    soft_reset = 1'b1;
    drive(1'b1, 1'b0, 8'h55, 1'b0);
    soft_reset = 1'b0;
    check("srst_empty", 32'(empty), 32'd1);
    check("srst_dout",  32'(data_out), 32'h0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 600; i++) begin
      soft_reset = ($urandom_range(0, 63) == 0);
      drive(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 3) == 0),
            8'($urandom), 1'($urandom_range(0, 99) < 50));
    end
    soft_reset = 1'b0;
    while (q.size() != 0) drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Idle-read watchdog (or its absence)
    drive(1'b1, 1'b0, 8'h77, 1'b0);
    n = 0;
    seen = 1'b0;
`ifdef ROUTER_DEST_FIFO_TIMEOUT_EN
    while (!seen && n < 100) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      n++;
      if (timeout) begin
        seen = 1'b1;
        check("tmo_empty", 32'(empty), 32'd1);
      end
    end
    check("tmo_cycle", 32'(n), 32'(TMO));
`else
    for (int i = 0; i < 60; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("no_tmo_valid", 32'(valid_out), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
